// File: rtl/pwm_duty_sequencer_if.sv
// Target-duty configuration handshake between the CPU register block and pwm_duty_sequencer.
interface pwm_duty_sequencer_if #(
    parameter int unsigned W = 32
);
    logic         Cfg_Valid;
    logic         Cfg_Ready;
    logic [W-1:0] Cfg_Duty_0;
    logic [W-1:0] Cfg_Duty_1;
    logic [W-1:0] Cfg_Duty_2;

    modport master (
        output Cfg_Valid,
        output Cfg_Duty_0,
        output Cfg_Duty_1,
        output Cfg_Duty_2,
        input  Cfg_Ready
    );

    modport slave (
        input  Cfg_Valid,
        input  Cfg_Duty_0,
        input  Cfg_Duty_1,
        input  Cfg_Duty_2,
        output Cfg_Ready
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Three-phase PWM duty sequencer: ramps duties toward targets on period sync events, handles fault shutdown.
// Optional soft stop (ramp-down before IDLE) enabled by defining PWM_SEQ_SOFTSTOP_EN.
module pwm_duty_sequencer #(
    parameter int unsigned W = 32
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 Fault,
    input  logic                 Fault_Clear,
    pwm_duty_sequencer_if.slave  cfg,
    input  logic [W-1:0]         Ramp_Step,
    input  logic                 Period_Sync,
    output logic                 Interrupt_Clear,
    output logic [W-1:0]         Duty_0,
    output logic [W-1:0]         Duty_1,
    output logic [W-1:0]         Duty_2,
    output logic                 Pwm_Enable,
    output logic                 Busy,
    output logic                 Fault_Latched
);

    localparam int unsigned NCH = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
`ifdef PWM_SEQ_SOFTSTOP_EN
        ST_STOPPING = 2'd2,
`endif
        ST_FAULT    = 2'd3
    } state_e;

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] duty_q   [NCH];
    logic [W-1:0] duty_d   [NCH];
    logic [W-1:0] target_q [NCH];
    logic [W-1:0] target_d [NCH];
    logic         sync_q;
    logic         sync_qq;
    logic         sync_event;
    logic         accept;
    logic         cfg_ready_q;
    logic         int_clr_q;
    logic         en_q;
    logic         en_d;
    logic         busy_q;
    logic         busy_d;
    logic         fault_q;

    // One step toward tgt, never past it; a zero step means jump straight there.
    function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                                 input logic [W-1:0] tgt,
                                                 input logic [W-1:0] step);
        logic [W-1:0] diff;
        logic [W-1:0] mag;
        diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        mag  = ((step == '0) || (step > diff)) ? diff : step;
        return (tgt >= cur) ? (cur + mag) : (cur - mag);
    endfunction

    assign sync_event = sync_q & ~sync_qq;
    assign accept     = cfg.Cfg_Valid & cfg_ready_q;

`ifdef PWM_SEQ_SOFTSTOP_EN
    logic all_zero;
    assign all_zero = ((duty_q[0] | duty_q[1] | duty_q[2]) == '0);
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next duties/targets and registered-output values
    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            duty_d[i]   = duty_q[i];
            target_d[i] = target_q[i];
        end

        if (accept) begin
            target_d[0] = cfg.Cfg_Duty_0;
            target_d[1] = cfg.Cfg_Duty_1;
            target_d[2] = cfg.Cfg_Duty_2;
        end

        if (Fault) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start && !Stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (Stop) begin
`ifdef PWM_SEQ_SOFTSTOP_EN
                        state_d = ST_STOPPING;
`else
                        state_d = ST_IDLE;
`endif
                    end else if (sync_event) begin
                        // Step uses the registered targets so a same-cycle accept waits for the next event
                        for (int i = 0; i < NCH; i++) begin
                            duty_d[i] = step_toward(duty_q[i], target_q[i], Ramp_Step);
                        end
                    end
                end
`ifdef PWM_SEQ_SOFTSTOP_EN
                ST_STOPPING: begin
                    if (all_zero) begin
                        state_d = ST_IDLE;
                    end else if (sync_event) begin
                        for (int i = 0; i < NCH; i++) begin
                            duty_d[i] = step_toward(duty_q[i], W'(0), Ramp_Step);
                        end
                    end
                end
`endif
                ST_FAULT: begin
                    if (Fault_Clear) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        case (state_d)
            ST_RUN: en_d = 1'b1;
`ifdef PWM_SEQ_SOFTSTOP_EN
            ST_STOPPING: begin
                en_d = 1'b1;
                for (int i = 0; i < NCH; i++) target_d[i] = W'(0);
            end
`endif
            default: begin
                for (int i = 0; i < NCH; i++) duty_d[i] = W'(0);
            end
        endcase

        if (state_d == ST_RUN) begin
            for (int i = 0; i < NCH; i++) begin
                if (duty_d[i] != target_d[i]) busy_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                duty_q[i]   <= W'(0);
                target_q[i] <= W'(0);
            end
            sync_q      <= 1'b0;
            sync_qq     <= 1'b0;
            int_clr_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                duty_q[i]   <= duty_d[i];
                target_q[i] <= target_d[i];
            end
            sync_q      <= Period_Sync;
            sync_qq     <= sync_q;
            int_clr_q   <= sync_event;
            cfg_ready_q <= (state_d == ST_IDLE) || (state_d == ST_RUN);
            en_q        <= en_d;
            busy_q      <= busy_d;
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign Duty_0          = duty_q[0];
    assign Duty_1          = duty_q[1];
    assign Duty_2          = duty_q[2];
    assign Pwm_Enable      = en_q;
    assign Busy            = busy_q;
    assign Fault_Latched   = fault_q;
    assign Interrupt_Clear = int_clr_q;
    assign cfg.Cfg_Ready   = cfg_ready_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: directed scenarios plus random ops against a reference model.
module tb_pwm_duty_sequencer;

    localparam int unsigned W = 32;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic         Stop;
    logic         Fault;
    logic         Fault_Clear;
    logic [W-1:0] Ramp_Step;
    logic         Period_Sync;
    logic         Interrupt_Clear;
    logic [W-1:0] Duty_0;
    logic [W-1:0] Duty_1;
    logic [W-1:0] Duty_2;
    logic         Pwm_Enable;
    logic         Busy;
    logic         Fault_Latched;

    pwm_duty_sequencer_if #(.W(W)) cfg_if ();

    pwm_duty_sequencer #(.W(W)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Start           (Start),
        .Stop            (Stop),
        .Fault           (Fault),
        .Fault_Clear     (Fault_Clear),
        .cfg             (cfg_if),
        .Ramp_Step       (Ramp_Step),
        .Period_Sync     (Period_Sync),
        .Interrupt_Clear (Interrupt_Clear),
        .Duty_0          (Duty_0),
        .Duty_1          (Duty_1),
        .Duty_2          (Duty_2),
        .Pwm_Enable      (Pwm_Enable),
        .Busy            (Busy),
        .Fault_Latched   (Fault_Latched)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    int ic_count = 0;

    // Reference model: operating mode flags plus duty/target values
    longint unsigned m_duty [3];
    longint unsigned m_tgt  [3];
    bit m_run;
    bit m_soft;
    bit m_fault;

    function automatic logic [W-1:0] dut_duty(input int ch);
        case (ch)
            0:       return Duty_0;
            1:       return Duty_1;
            default: return Duty_2;
        endcase
    endfunction

    function automatic longint unsigned ramp(input longint unsigned cur,
                                             input longint unsigned tgt,
                                             input longint unsigned step);
        longint unsigned gap;
        longint unsigned mv;
        gap = (tgt > cur) ? tgt - cur : cur - tgt;
        mv  = (step == 0 || step > gap) ? gap : step;
        return (tgt > cur) ? cur + mv : cur - mv;
    endfunction

    function automatic bit m_ready();
        return !m_fault && !m_soft;
    endfunction

    function automatic bit m_enable();
        return m_run || m_soft;
    endfunction

    function automatic bit m_busy();
        bit b;
        b = 1'b0;
        for (int c = 0; c < 3; c++) if (m_duty[c] != m_tgt[c]) b = 1'b1;
        return m_run && b;
    endfunction

    function automatic bit m_all_zero();
        return (m_duty[0] == 0) && (m_duty[1] == 0) && (m_duty[2] == 0);
    endfunction

    task automatic m_event();
        if (m_run || m_soft) begin
            for (int c = 0; c < 3; c++) m_duty[c] = ramp(m_duty[c], m_tgt[c], longint'(Ramp_Step));
        end
        if (m_soft && m_all_zero()) m_soft = 1'b0;
    endtask

    task automatic do_start();
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        if (!m_run && !m_soft && !m_fault) m_run = 1'b1;
    endtask

    task automatic do_stop();
        @(negedge Clk) Stop = 1'b1;
        @(negedge Clk) Stop = 1'b0;
        if (m_run) begin
            m_run = 1'b0;
`ifdef PWM_SEQ_SOFTSTOP_EN
            m_soft = 1'b1;
            for (int c = 0; c < 3; c++) m_tgt[c] = 0;
            if (m_all_zero()) m_soft = 1'b0;
`else
            for (int c = 0; c < 3; c++) m_duty[c] = 0;
`endif
        end
    endtask

    task automatic do_cfg(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
        @(negedge Clk);
        cfg_if.Cfg_Valid  = 1'b1;
        cfg_if.Cfg_Duty_0 = d0;
        cfg_if.Cfg_Duty_1 = d1;
        cfg_if.Cfg_Duty_2 = d2;
        @(negedge Clk) cfg_if.Cfg_Valid = 1'b0;
        if (m_ready()) begin
            m_tgt[0] = d0; m_tgt[1] = d1; m_tgt[2] = d2;
        end
    endtask

    // One-cycle Period_Sync pulse; optionally offer a target set in the cycle the event is acted on
    task automatic do_sync(input bit with_cfg, input logic [W-1:0] d0,
                           input logic [W-1:0] d1, input logic [W-1:0] d2);
        bit acc;
        acc = 1'b0;
        @(negedge Clk) Period_Sync = 1'b1;
        @(negedge Clk);
        Period_Sync = 1'b0;
        if (with_cfg) begin
            cfg_if.Cfg_Valid  = 1'b1;
            cfg_if.Cfg_Duty_0 = d0;
            cfg_if.Cfg_Duty_1 = d1;
            cfg_if.Cfg_Duty_2 = d2;
            acc = m_ready();
        end
        @(negedge Clk);
        cfg_if.Cfg_Valid = 1'b0;
        ic_count = int'(Interrupt_Clear);
        repeat (2) begin
            @(negedge Clk);
            ic_count += int'(Interrupt_Clear);
        end
        m_event();
        if (acc) begin
            m_tgt[0] = d0; m_tgt[1] = d1; m_tgt[2] = d2;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Start = 1'b0; Stop = 1'b0; Fault = 1'b0; Fault_Clear = 1'b0;
        Period_Sync = 1'b0; Ramp_Step = '0;
        cfg_if.Cfg_Valid = 1'b0; cfg_if.Cfg_Duty_0 = '0; cfg_if.Cfg_Duty_1 = '0; cfg_if.Cfg_Duty_2 = '0;
        for (int c = 0; c < 3; c++) begin m_duty[c] = 0; m_tgt[c] = 0; end
        m_run = 1'b0; m_soft = 1'b0; m_fault = 1'b0;
        repeat (3) @(negedge Clk);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (dut_duty(c) !== '0) begin n_err++; $display("FAIL reset_duty%0d: got %0d want 0", c, dut_duty(c)); end
        end
        n_vec++; if (Pwm_Enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %b want 0", Pwm_Enable); end
        n_vec++; if (Interrupt_Clear !== 1'b0) begin n_err++; $display("FAIL reset_intclr: got %b want 0", Interrupt_Clear); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_vec++; if (Fault_Latched !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", Fault_Latched); end
        n_vec++; if (cfg_if.Cfg_Ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cfg_if.Cfg_Ready); end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_start_zero();
        do_start();
        n_vec++; if (Pwm_Enable !== 1'b1) begin n_err++; $display("FAIL start_enable: got %b want 1", Pwm_Enable); end
        do_sync(1'b0, '0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (dut_duty(c) !== '0) begin n_err++; $display("FAIL start_duty%0d: got %0d want 0", c, dut_duty(c)); end
        end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL start_busy: got %b want 0", Busy); end
        n_vec++; if (ic_count != 1) begin n_err++; $display("FAIL start_intclr: got %0d pulses want 1", ic_count); end
    endtask

    task automatic test_ramp_up();
        logic [W-1:0] exp0 [3];
        exp0[0] = 100; exp0[1] = 200; exp0[2] = 250;
        Ramp_Step = 100;
        do_cfg(250, 0, 100);
        for (int k = 0; k < 3; k++) begin
            do_sync(1'b0, '0, '0, '0);
            n_vec++; if (Duty_0 !== exp0[k]) begin n_err++; $display("FAIL up_duty0_ev%0d: got %0d want %0d", k, Duty_0, exp0[k]); end
            n_vec++; if (Duty_1 !== '0) begin n_err++; $display("FAIL up_duty1_ev%0d: got %0d want 0", k, Duty_1); end
            n_vec++; if (Duty_2 !== W'(100)) begin n_err++; $display("FAIL up_duty2_ev%0d: got %0d want 100", k, Duty_2); end
            n_vec++; if (Busy !== (k < 2)) begin n_err++; $display("FAIL up_busy_ev%0d: got %b want %b", k, Busy, (k < 2)); end
        end
    endtask

    task automatic test_ramp_down();
        logic [W-1:0] exp0 [3];
        exp0[0] = 150; exp0[1] = 50; exp0[2] = 30;
        do_cfg(30, 0, 100);
        for (int k = 0; k < 3; k++) begin
            do_sync(1'b0, '0, '0, '0);
            n_vec++; if (Duty_0 !== exp0[k]) begin n_err++; $display("FAIL down_duty0_ev%0d: got %0d want %0d", k, Duty_0, exp0[k]); end
        end
    endtask

    task automatic test_sync_held();
        int ic;
        ic = 0;
        do_cfg(500, 0, 100);
        @(negedge Clk) Period_Sync = 1'b1;
        repeat (5) begin @(negedge Clk); ic += int'(Interrupt_Clear); end
        Period_Sync = 1'b0;
        repeat (4) begin @(negedge Clk); ic += int'(Interrupt_Clear); end
        m_event();
        n_vec++; if (ic != 1) begin n_err++; $display("FAIL held_intclr: got %0d pulses want 1", ic); end
        n_vec++; if (Duty_0 !== W'(130)) begin n_err++; $display("FAIL held_duty0: got %0d want 130", Duty_0); end
    endtask

    task automatic test_fault();
        do_sync(1'b0, '0, '0, '0);
        n_vec++; if (Duty_0 !== W'(230)) begin n_err++; $display("FAIL fault_pre_duty0: got %0d want 230", Duty_0); end
        @(negedge Clk) Fault = 1'b1;
        @(negedge Clk);
        m_run = 1'b0; m_fault = 1'b1;
        for (int c = 0; c < 3; c++) m_duty[c] = 0;
        n_vec++; if (Pwm_Enable !== 1'b0) begin n_err++; $display("FAIL fault_enable: got %b want 0", Pwm_Enable); end
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (dut_duty(c) !== '0) begin n_err++; $display("FAIL fault_duty%0d: got %0d want 0", c, dut_duty(c)); end
        end
        n_vec++; if (cfg_if.Cfg_Ready !== 1'b0) begin n_err++; $display("FAIL fault_ready: got %b want 0", cfg_if.Cfg_Ready); end
        n_vec++; if (Fault_Latched !== 1'b1) begin n_err++; $display("FAIL fault_latched: got %b want 1", Fault_Latched); end
        @(negedge Clk) Fault_Clear = 1'b1;
        @(negedge Clk) Fault_Clear = 1'b0;
        @(negedge Clk);
        n_vec++; if (Fault_Latched !== 1'b1) begin n_err++; $display("FAIL fault_clear_ignored: got %b want 1", Fault_Latched); end
        Fault = 1'b0;
        @(negedge Clk) Fault_Clear = 1'b1;
        @(negedge Clk) Fault_Clear = 1'b0;
        m_fault = 1'b0;
        n_vec++; if (Fault_Latched !== 1'b0) begin n_err++; $display("FAIL fault_cleared: got %b want 0", Fault_Latched); end
        n_vec++; if (cfg_if.Cfg_Ready !== 1'b1) begin n_err++; $display("FAIL fault_idle_ready: got %b want 1", cfg_if.Cfg_Ready); end
        n_vec++; if (Pwm_Enable !== 1'b0) begin n_err++; $display("FAIL fault_idle_enable: got %b want 0", Pwm_Enable); end
    endtask

    task automatic test_stop();
        Ramp_Step = 100;
        do_cfg(300, 0, 0);
        n_vec++; if (Duty_0 !== '0) begin n_err++; $display("FAIL stop_idle_duty0: got %0d want 0", Duty_0); end
        do_start();
        repeat (3) do_sync(1'b0, '0, '0, '0);
        n_vec++; if (Duty_0 !== W'(300)) begin n_err++; $display("FAIL stop_pre_duty0: got %0d want 300", Duty_0); end
        do_stop();
`ifdef PWM_SEQ_SOFTSTOP_EN
        n_vec++; if (Pwm_Enable !== 1'b1) begin n_err++; $display("FAIL soft_enable: got %b want 1", Pwm_Enable); end
        n_vec++; if (cfg_if.Cfg_Ready !== 1'b0) begin n_err++; $display("FAIL soft_ready: got %b want 0", cfg_if.Cfg_Ready); end
        for (int k = 0; k < 3; k++) begin
            do_sync(1'b0, '0, '0, '0);
            n_vec++;
            if (Duty_0 !== W'(200 - 100 * k)) begin
                n_err++; $display("FAIL soft_duty0_ev%0d: got %0d want %0d", k, Duty_0, 200 - 100 * k);
            end
        end
        n_vec++; if (Pwm_Enable !== 1'b0) begin n_err++; $display("FAIL soft_idle_enable: got %b want 0", Pwm_Enable); end
`else
        n_vec++; if (Pwm_Enable !== 1'b0) begin n_err++; $display("FAIL stop_enable: got %b want 0", Pwm_Enable); end
        n_vec++; if (Duty_0 !== '0) begin n_err++; $display("FAIL stop_duty0: got %0d want 0", Duty_0); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", Busy); end
`endif
    endtask

    task automatic test_random();
        int unsigned op;
        logic [W-1:0] r [3];
        bit synced;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            synced = 1'b0;
            for (int c = 0; c < 3; c++)
                r[c] = ($urandom_range(0, 3) == 0) ? W'($urandom()) : W'($urandom_range(0, 1200));
            case (op)
                0, 1:       do_cfg(r[0], r[1], r[2]);
                2, 3, 4, 5: begin do_sync(1'b0, '0, '0, '0); synced = 1'b1; end
                6:          begin do_sync(1'b1, r[0], r[1], r[2]); synced = 1'b1; end
                7:          do_start();
                8:          begin do_stop(); repeat (2) @(negedge Clk); end
                default: begin
                    @(negedge Clk);
                    Ramp_Step = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 400));
                end
            endcase
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (dut_duty(c) !== W'(m_duty[c])) begin
                    n_err++; $display("FAIL rnd%0d_duty%0d: got %0d want %0d", it, c, dut_duty(c), W'(m_duty[c]));
                end
            end
            n_vec++; if (Pwm_Enable !== m_enable()) begin n_err++; $display("FAIL rnd%0d_enable: got %b want %b", it, Pwm_Enable, m_enable()); end
            n_vec++; if (Busy !== m_busy()) begin n_err++; $display("FAIL rnd%0d_busy: got %b want %b", it, Busy, m_busy()); end
            n_vec++; if (cfg_if.Cfg_Ready !== m_ready()) begin n_err++; $display("FAIL rnd%0d_ready: got %b want %b", it, cfg_if.Cfg_Ready, m_ready()); end
            if (synced) begin
                n_vec++; if (ic_count != 1) begin n_err++; $display("FAIL rnd%0d_intclr: got %0d pulses want 1", it, ic_count); end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_start_zero();
        test_ramp_up();
        test_ramp_down();
        test_sync_held();
        test_fault();
        test_stop();
        do_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
